// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment display (active-low
// anodes and segments), decodes each digit and reassembles the 4-digit frame
// into its binary value. Used for display loopback and for reading external
// display units.
// Optional build macro SEG7_SCAN_STATS_EN adds saturating good/bad frame
// counters (good_cnt_o, bad_cnt_o).
module seg7_scan_decoder #(
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an_i,
   input  logic [6:0]  seg_i,
   output logic [13:0] value_o,
   output logic        value_valid_o,
   output logic        error_disp_o,
   output logic        frame_err_o,
   output logic        stale_o,
`ifdef SEG7_SCAN_STATS_EN
   output logic [7:0]  good_cnt_o,
   output logic [7:0]  bad_cnt_o,
`endif
   output logic [15:0] digits_o
);

   localparam logic [3:0]  SETTLE_L = 4'(SETTLE_CYC);
   localparam logic [15:0] TO_L     = 16'(TIMEOUT_CYC);
   localparam logic [15:0] TO_M1    = 16'(TIMEOUT_CYC - 1);

   logic [10:0] sync1, sync2, prev_q;
   logic [3:0]  an_s;
   logic [6:0]  seg_s;
   logic [3:0]  settle_q, settle_next;
   logic        captured_q;
   logic [15:0] to_q;
   logic [15:0] codes_q, codes_next;
   logic [3:0]  mask_q, mask_next, capbit;
   logic [3:0]  code_dec;
   logic [1:0]  sel;
   logic        onehot, an_chg, smp_chg, capture, timeout_hit, complete;
   logic        all_dash, all_num;
   logic [13:0] d0, d1, d2, d3, sum;

   // Active-high pattern {g..a} to digit code; 0xA dash, 0xB blank, 0xF invalid.
   function automatic logic [3:0] decode(input logic [6:0] hi);
      case (hi)
         7'h3F: decode = 4'd0;
         7'h06: decode = 4'd1;
         7'h5B: decode = 4'd2;
         7'h4F: decode = 4'd3;
         7'h66: decode = 4'd4;
         7'h6D: decode = 4'd5;
         7'h7D: decode = 4'd6;
         7'h07: decode = 4'd7;
         7'h27: decode = 4'd7;
         7'h7F: decode = 4'd8;
         7'h6F: decode = 4'd9;
         7'h40: decode = 4'hA;
         7'h00: decode = 4'hB;
         default: decode = 4'hF;
      endcase
   endfunction

   function automatic logic is_num(input logic [3:0] c);
      is_num = (c <= 4'd9) || (c == 4'hB);
   endfunction

   // Blank digits contribute zero (leading-zero blanking).
   function automatic logic [13:0] dig_val(input logic [3:0] c);
      dig_val = (c == 4'hB) ? 14'd0 : {10'd0, c};
   endfunction

   assign an_s  = sync2[10:7];
   assign seg_s = sync2[6:0];

   // Two-flop synchronizer; idles at all-ones (display off).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {an_i, seg_i};
         sync2 <= sync1;
      end
   end

   // Qualification, capture, frame assembly and frame classification.
   always_comb begin
      onehot = 1'b0;
      sel    = 2'd0;
      case (an_s)
         4'b1110: begin onehot = 1'b1; sel = 2'd0; end
         4'b1101: begin onehot = 1'b1; sel = 2'd1; end
         4'b1011: begin onehot = 1'b1; sel = 2'd2; end
         4'b0111: begin onehot = 1'b1; sel = 2'd3; end
         default: begin onehot = 1'b0; sel = 2'd0; end
      endcase
      an_chg  = (an_s != prev_q[10:7]);
      smp_chg = (sync2 != prev_q);
      // settle_next counts consecutive cycles of an unchanged sample, this one included
      if (!onehot)
         settle_next = 4'd0;
      else if (smp_chg)
         settle_next = 4'd1;
      else if (settle_q < SETTLE_L)
         settle_next = settle_q + 4'd1;
      else
         settle_next = settle_q;
      capture     = onehot && (settle_next == SETTLE_L) && (!captured_q || an_chg);
      timeout_hit = !an_chg && (to_q == TO_M1);
      code_dec    = decode(~seg_s);
      codes_next  = codes_q;
      if (capture)
         codes_next[{sel, 2'b00} +: 4] = code_dec;
      capbit    = capture ? ~an_s : 4'd0;
      mask_next = (timeout_hit ? 4'd0 : mask_q) | capbit;
      complete  = (mask_next == 4'hF);
      all_dash  = (codes_next == 16'hAAAA);
      all_num   = is_num(codes_next[3:0])  && is_num(codes_next[7:4]) &&
                  is_num(codes_next[11:8]) && is_num(codes_next[15:12]);
      d0  = dig_val(codes_next[3:0]);
      d1  = dig_val(codes_next[7:4]);
      d2  = dig_val(codes_next[11:8]);
      d3  = dig_val(codes_next[15:12]);
      sum = ((d3 << 10) - (d3 << 4) - (d3 << 3)) +
            ((d2 << 6) + (d2 << 5) + (d2 << 2)) +
            ((d1 << 3) + (d1 << 1)) + d0;
   end

   // Front end: previous sample, settle counter, one-capture-per-dwell flag, timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q     <= '1;
         settle_q   <= 4'd0;
         captured_q <= 1'b0;
         to_q       <= 16'd0;
      end else begin
         prev_q   <= sync2;
         settle_q <= timeout_hit ? 4'd0 : settle_next;
         if (capture)
            captured_q <= 1'b1;
         else if (an_chg)
            captured_q <= 1'b0;
         if (an_chg)
            to_q <= 16'd0;
         else if (to_q != TO_L)
            to_q <= to_q + 16'd1;
      end
   end

   // Captured digit codes and capture mask; mask clears when the frame completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         codes_q <= 16'd0;
         mask_q  <= 4'd0;
      end else begin
         codes_q <= codes_next;
         mask_q  <= complete ? 4'd0 : mask_next;
      end
   end

   // Registered results; pulses are high for one cycle after frame completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_o       <= 14'd0;
         digits_o      <= 16'd0;
         value_valid_o <= 1'b0;
         frame_err_o   <= 1'b0;
         error_disp_o  <= 1'b0;
         stale_o       <= 1'b0;
      end else begin
         value_valid_o <= complete && all_num;
         frame_err_o   <= complete && !all_num && !all_dash;
         if (complete) begin
            digits_o <= codes_next;
            if (all_dash) begin
               error_disp_o <= 1'b1;
            end else if (all_num) begin
               value_o      <= sum;
               error_disp_o <= 1'b0;
            end
         end
         if (timeout_hit)
            stale_o <= 1'b1;
         else if (capture)
            stale_o <= 1'b0;
      end
   end

`ifdef SEG7_SCAN_STATS_EN
   // Saturating frame statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         good_cnt_o <= 8'd0;
         bad_cnt_o  <= 8'd0;
      end else begin
         if (value_valid_o && good_cnt_o != 8'hFF)
            good_cnt_o <= good_cnt_o + 8'd1;
         if (frame_err_o && bad_cnt_o != 8'hFF)
            bad_cnt_o <= bad_cnt_o + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: the stimulus side pushes the
// expected frame result computed from a digit lookup model; a monitor pops
// and compares whenever the DUT reports a frame.
module tb_seg7_scan_decoder;

   localparam int SETTLE = 4;
   localparam int TMO    = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  an_i = 4'hF;
   logic [6:0]  seg_i = 7'h7F;
   logic [13:0] value_o;
   logic        value_valid_o, error_disp_o, frame_err_o, stale_o;
   logic [15:0] digits_o;
`ifdef SEG7_SCAN_STATS_EN
   logic [7:0]  good_cnt_o, bad_cnt_o;
`endif

   seg7_scan_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .an_i(an_i), .seg_i(seg_i),
      .value_o(value_o), .value_valid_o(value_valid_o),
      .error_disp_o(error_disp_o), .frame_err_o(frame_err_o),
      .stale_o(stale_o),
`ifdef SEG7_SCAN_STATS_EN
      .good_cnt_o(good_cnt_o), .bad_cnt_o(bad_cnt_o),
`endif
      .digits_o(digits_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          vp;
      bit          fe;
      logic [13:0] val;
      logic [15:0] dig;
      bit          ed;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_value = 0;
   bit   m_err   = 0;
   bit   last_dash = 0;
   int   m_good = 0, m_bad = 0;

   int std_pat [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic int model_code(input logic [6:0] seg_low);
      logic [6:0] hi;
      hi = ~seg_low;
      for (int i = 0; i < 10; i++)
         if (int'(hi) == std_pat[i]) return i;
      if (hi == 7'h27) return 7;
      if (hi == 7'h40) return 10;
      if (hi == 7'h00) return 11;
      return 15;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] p;
      p = 7'(std_pat[d]);
      return ~p;
   endfunction

   function automatic logic [6:0] rand_seg();
      int x;
      x = $urandom_range(0, 23);
      if (x < 20) return seg_of(x % 10);
      if (x == 20) return 7'h7F;
      if (x == 21) return 7'h3F;
      if (x == 22) return 7'h58;
      return 7'($urandom);
   endfunction

   function automatic bit is_dash_frame(input logic [6:0] s3, s2, s1, s0);
      return model_code(s3) == 10 && model_code(s2) == 10 &&
             model_code(s1) == 10 && model_code(s0) == 10;
   endfunction

   task automatic expect_frame(input logic [6:0] s3, s2, s1, s0);
      int   c[4];
      bit   dash, num;
      exp_t e;
      c[3] = model_code(s3); c[2] = model_code(s2);
      c[1] = model_code(s1); c[0] = model_code(s0);
      dash = 1; num = 1;
      for (int k = 0; k < 4; k++) begin
         if (c[k] != 10) dash = 0;
         if (!(c[k] <= 9 || c[k] == 11)) num = 0;
      end
      e.dig = {4'(c[3]), 4'(c[2]), 4'(c[1]), 4'(c[0])};
      e.vp = 0; e.fe = 0;
      if (dash) begin
         m_err = 1;
      end else if (num) begin
         m_value = 0;
         for (int k = 3; k >= 0; k--)
            m_value = m_value * 10 + ((c[k] == 11) ? 0 : c[k]);
         m_err = 0;
         e.vp = 1;
         m_good++;
      end else begin
         e.fe = 1;
         m_bad++;
      end
      e.val = 14'(m_value);
      e.ed  = m_err;
      last_dash = dash;
      exp_q.push_back(e);
   endtask

   task automatic scan_digit(input int k, input logic [6:0] s, input int dwell);
      @(negedge clk);
      an_i  = ~(4'd1 << k);
      seg_i = s;
      repeat (dwell - 1) @(negedge clk);
   endtask

   task automatic scan_frame(input logic [6:0] s3, s2, s1, s0,
                             input int lo, input int hi, input bit expect_it);
      if (expect_it) expect_frame(s3, s2, s1, s0);
      scan_digit(3, s3, $urandom_range(hi, lo));
      scan_digit(2, s2, $urandom_range(hi, lo));
      scan_digit(1, s1, $urandom_range(hi, lo));
      scan_digit(0, s0, $urandom_range(hi, lo));
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_value"}, 32'(value_o), 32'd0);
      check({tag, "_digits"}, 32'(digits_o), 32'd0);
      check({tag, "_valid"}, 32'(value_valid_o), 32'd0);
      check({tag, "_frame_err"}, 32'(frame_err_o), 32'd0);
      check({tag, "_error_disp"}, 32'(error_disp_o), 32'd0);
      check({tag, "_stale"}, 32'(stale_o), 32'd0);
   endtask

   // Monitor: a frame report is any pulse or any change of digits/error display.
   logic [15:0] prev_dig = '0;
   logic        prev_ed  = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_dig <= digits_o;
         prev_ed  <= error_disp_o;
      end else begin
         if (value_valid_o || frame_err_o || digits_o !== prev_dig || error_disp_o !== prev_ed) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_frame: got value=%0d digits=%h valid=%0d ferr=%0d edisp=%0d, expected no report",
                        value_o, digits_o, value_valid_o, frame_err_o, error_disp_o);
            end else begin
               e = exp_q.pop_front();
               check("valid_pulse", 32'(value_valid_o), 32'(e.vp));
               check("frame_err_pulse", 32'(frame_err_o), 32'(e.fe));
               check("value", 32'(value_o), 32'(e.val));
               check("digits", 32'(digits_o), 32'(e.dig));
               check("error_disp", 32'(error_disp_o), 32'(e.ed));
            end
         end
         prev_dig <= digits_o;
         prev_ed  <= error_disp_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] s[4];
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1234, long dwells
      scan_frame(7'h79, 7'h24, 7'h30, 7'h19, 20, 20, 1);
      wait_drain();
      // blank, blank, 4, 7
      scan_frame(7'h7F, 7'h7F, 7'h19, 7'h78, 20, 20, 1);
      wait_drain();
      // 250 then dashes then 0999
      scan_frame(seg_of(0), seg_of(2), seg_of(5), seg_of(0), 6, 12, 1);
      scan_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 6, 12, 1);
      scan_frame(seg_of(0), seg_of(9), seg_of(9), seg_of(9), 6, 12, 1);
      wait_drain();
      // invalid pattern in digit 2
      scan_frame(seg_of(1), 7'h55, seg_of(3), seg_of(4), 6, 12, 1);
      wait_drain();
      // glitchy scans never capture; exact settle dwell does
      scan_frame(seg_of(8), seg_of(8), seg_of(8), seg_of(8), SETTLE - 1, SETTLE - 1, 0);
      scan_frame(seg_of(3), seg_of(1), seg_of(4), seg_of(1), SETTLE - 1, SETTLE - 1, 0);
      scan_frame(seg_of(6), seg_of(0), seg_of(2), seg_of(5), SETTLE, SETTLE, 1);
      wait_drain();

      // randomized frames
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0 && !last_dash) begin
            for (int k = 0; k < 4; k++) s[k] = 7'h3F;
         end else begin
            for (int k = 0; k < 4; k++) s[k] = rand_seg();
            if (last_dash && is_dash_frame(s[3], s[2], s[1], s[0])) s[0] = seg_of(1);
         end
         scan_frame(s[3], s[2], s[1], s[0], SETTLE, SETTLE + 8, 1);
      end
      wait_drain();

      // timeout discards a partial frame and raises stale
      scan_digit(3, seg_of(9), 10);
      scan_digit(2, seg_of(9), 10);
      @(negedge clk);
      an_i = 4'hF;
      seg_i = 7'h7F;
      repeat (90) @(negedge clk);
      check("stale_before_timeout", 32'(stale_o), 32'd0);
      repeat (20) @(negedge clk);
      check("stale_after_timeout", 32'(stale_o), 32'd1);
      scan_digit(1, seg_of(7), 10);
      scan_digit(0, seg_of(8), 10);
      check("stale_cleared_by_capture", 32'(stale_o), 32'd0);
      expect_frame(seg_of(5), seg_of(6), seg_of(7), seg_of(8));
      scan_digit(3, seg_of(5), 10);
      scan_digit(2, seg_of(6), 10);
      wait_drain();
      check("stale_after_frame", 32'(stale_o), 32'd0);

      // asynchronous reset mid-frame
      scan_digit(3, seg_of(1), 10);
      scan_digit(2, seg_of(1), 10);
      @(negedge clk);
      an_i = 4'hF;
      seg_i = 7'h7F;
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      m_value = 0; m_err = 0; last_dash = 0; m_good = 0; m_bad = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      scan_digit(1, seg_of(2), 10);
      scan_digit(0, seg_of(1), 10);
      expect_frame(seg_of(4), seg_of(3), seg_of(2), seg_of(1));
      scan_digit(3, seg_of(4), 10);
      scan_digit(2, seg_of(3), 10);
      wait_drain();

`ifdef SEG7_SCAN_STATS_EN
      check("good_cnt", 32'(good_cnt_o), 32'(m_good));
      check("bad_cnt", 32'(bad_cnt_o), 32'(m_bad));
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
